// File: rtl/cache_perf_monitor.sv
// Performance monitor for the pipelined CPU with direct-mapped caches.
// It observes NUM_CH cache channels and counts cycles, retired accesses and
// miss-stall cycles, applying jump/flush corrections. A run starts on a start
// pulse and ends when ch0 delivers the syscall halt word, or on a cycle timeout.
// The run then reports a per-channel hit-rate pass/fail flag, computed without
// a divider.
//
// start is a single-cycle pulse with no handshake. In any state it clears every
// counter, hit_ok, done and timeout, and the FSM enters RUN on the next cycle.
// The start cycle itself is not counted. All outputs come straight from
// registers, so there is no combinational path from any input to any output.
module cache_perf_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int INSTR_W     = 32,
  parameter int FLUSH_SLOTS = 2,
  parameter int MISS_PEN    = 2,
  parameter int HIT_PCT     = 50,
  parameter int DRAIN       = 3,
  parameter int TIMEOUT     = 1000,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'h0000000c
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         ch_stall,
  input  logic [NUM_CH*INSTR_W-1:0] ch_cache_instr,
  input  logic [NUM_CH*INSTR_W-1:0] ch_mem_instr,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [NUM_CH*CNT_W-1:0]   access_cnt,
  output logic [NUM_CH*CNT_W-1:0]   miss_cyc,
  output logic [NUM_CH-1:0]         hit_ok,
  output logic                      running,
  output logic                      done,
  output logic                      timeout,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_TOUT  = 3'd4
  } state_t;

  // Signed working width for the one-step counter update. It is wide enough
  // that counter + delta can neither overflow nor wrap before the clamp.
  localparam int SW  = CNT_W + 8;
  // Width of the intermediate used by the hit-rate comparison.
  localparam int HW  = 2 * CNT_W + 8;
  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic signed [SW-1:0] D_ONE  = SW'(1);
  localparam logic signed [SW-1:0] D_JUMP = SW'(1 - FLUSH_SLOTS);
  localparam logic signed [SW-1:0] MAX_V  = $signed({8'd0, {CNT_W{1'b1}}});

  state_t                         state_q, state_d;
  logic [DCW-1:0]                 drain_q, drain_d;
  logic [CNT_W-1:0]               cycle_q, cycle_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]   acc_q, acc_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]   miss_q, miss_nxt;
  logic [NUM_CH-1:0]              hit_q, hit_nxt;
  logic                           counting;
  logic                           halt_seen;
  logic                           at_limit;
  logic                           drain_last;

  // Decodes j (000010), jal (000011) and jr (opcode 0, funct 001000).
  function automatic logic is_jump(input logic [INSTR_W-1:0] w);
    return (w[31:26] == 6'b000010) || (w[31:26] == 6'b000011) ||
           ((w[31:26] == 6'b000000) && (w[5:0] == 6'b001000));
  endfunction

  // Adds a signed delta in one step, then clamps the result to [0, 2^CNT_W-1].
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                               input logic signed [SW-1:0] delta);
    logic signed [SW-1:0] sum;
    sum = $signed({8'd0, cur}) + delta;
    if (sum < 0)          return '0;
    else if (sum > MAX_V) return '1;
    else                  return sum[CNT_W-1:0];
  endfunction

  // Pass flag: A = accesses * MISS_PEN and M = miss cycles. The channel passes
  // when 100*(A-M) > HIT_PCT*A, with A-M floored at 0 and A = 0 never passing.
  function automatic logic hit_pass(input logic [CNT_W-1:0] acc,
                                    input logic [CNT_W-1:0] miss);
    logic [HW-1:0] a_w, m_w, d_w;
    a_w = HW'(acc) * HW'(MISS_PEN);
    m_w = HW'(miss);
    d_w = (m_w >= a_w) ? '0 : (a_w - m_w);
    return (a_w != '0) && ((d_w * HW'(100)) > (a_w * HW'(HIT_PCT)));
  endfunction

  assign counting   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign halt_seen  = (ch_cache_instr[INSTR_W-1:0] == HALT_WORD) && !ch_stall[0];
  assign at_limit   = (64'(cycle_q) == 64'(TIMEOUT - 1));
  assign drain_last = (drain_q == DCW'(DRAIN - 1));

  // State register and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic. Timeout wins over a halt seen in the same cycle.
  always_comb begin
    state_d = state_q;
    drain_d = '0;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (at_limit)       state_d = S_TOUT;
          else if (halt_seen) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          drain_d = drain_q + 1'b1;
          if (drain_last) state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Next counter values and pass flags. Jump corrections are folded into one
  // signed delta per counter.
  always_comb begin
    cycle_nxt = (&cycle_q) ? cycle_q : (cycle_q + 1'b1);
    acc_nxt   = acc_q;
    miss_nxt  = miss_q;
    hit_nxt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!ch_stall[k])
        acc_nxt[k] = sat_add(acc_q[k],
                             is_jump(ch_cache_instr[k*INSTR_W +: INSTR_W]) ? D_JUMP : D_ONE);
      else
        miss_nxt[k] = sat_add(miss_q[k],
                              is_jump(ch_mem_instr[k*INSTR_W +: INSTR_W]) ? D_JUMP : D_ONE);
      hit_nxt[k] = hit_pass(acc_nxt[k], miss_nxt[k]);
    end
  end

  // Counter registers. hit_ok is captured only on the DRAIN to DONE step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      acc_q   <= '0;
      miss_q  <= '0;
      hit_q   <= '0;
    end else if (start) begin
      cycle_q <= '0;
      acc_q   <= '0;
      miss_q  <= '0;
      hit_q   <= '0;
    end else if (counting) begin
      cycle_q <= cycle_nxt;
      acc_q   <= acc_nxt;
      miss_q  <= miss_nxt;
      if ((state_q == S_DRAIN) && drain_last) hit_q <= hit_nxt;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign access_cnt = acc_q;
  assign miss_cyc   = miss_q;
  assign hit_ok     = hit_q;
  assign running    = counting;
  assign done       = (state_q == S_DONE);
  assign timeout    = (state_q == S_TOUT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Bench for cache_perf_monitor. It drives a default instance and a
// CNT_W=4 instance from the same stimulus. Both are compared against a
// run-level reference model, plus directed tables and hand sequences.
`timescale 1ns/1ps
module tb_cache_perf_monitor;
  localparam int NUM_CH      = 2;
  localparam int INSTR_W     = 32;
  localparam int CNT_W       = 32;
  localparam int SMALL_W     = 4;
  localparam int FLUSH_SLOTS = 2;
  localparam int MISS_PEN    = 2;
  localparam int HIT_PCT     = 50;
  localparam int DRAIN       = 3;
  localparam int TIMEOUT     = 1000;
  localparam logic [31:0] HALT  = 32'h0000000c;
  localparam logic [31:0] NOP   = 32'h00000000;
  localparam logic [31:0] J_W   = 32'h08000005;
  localparam logic [31:0] JAL_W = 32'h0c000010;
  localparam logic [31:0] JR_W  = 32'h03e00008;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_TOUT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NUM_CH-1:0] ch_stall;
  logic [31:0] cache_w [NUM_CH];
  logic [31:0] mem_w [NUM_CH];
  logic [NUM_CH*INSTR_W-1:0] ch_cache_instr, ch_mem_instr;

  logic [CNT_W-1:0]        cycle_cnt;
  logic [NUM_CH*CNT_W-1:0] access_cnt, miss_cyc;
  logic [NUM_CH-1:0]       hit_ok;
  logic                    running, done, timeout;
  logic [2:0]              dbg_state;

  logic [SMALL_W-1:0]        s_cycle_cnt;
  logic [NUM_CH*SMALL_W-1:0] s_access_cnt, s_miss_cyc;
  logic [NUM_CH-1:0]         s_hit_ok;
  logic                      s_running, s_done, s_timeout;
  logic [2:0]                s_dbg_state;

  assign ch_cache_instr = {cache_w[1], cache_w[0]};
  assign ch_mem_instr   = {mem_w[1], mem_w[0]};

  always #5 clk = ~clk;

  cache_perf_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .ch_stall(ch_stall),
    .ch_cache_instr(ch_cache_instr), .ch_mem_instr(ch_mem_instr),
    .cycle_cnt(cycle_cnt), .access_cnt(access_cnt), .miss_cyc(miss_cyc),
    .hit_ok(hit_ok), .running(running), .done(done), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  cache_perf_monitor #(.CNT_W(SMALL_W)) u_small (
    .clk(clk), .rst(rst), .start(start), .ch_stall(ch_stall),
    .ch_cache_instr(ch_cache_instr), .ch_mem_instr(ch_mem_instr),
    .cycle_cnt(s_cycle_cnt), .access_cnt(s_access_cnt), .miss_cyc(s_miss_cyc),
    .hit_ok(s_hit_ok), .running(s_running), .done(s_done), .timeout(s_timeout),
    .dbg_state(s_dbg_state)
  );

  // ---------------- reference model (index 0: default, 1: CNT_W=4) ----------------
  longint m_cyc [2];
  longint m_acc [2][NUM_CH];
  longint m_miss [2][NUM_CH];
  bit     m_hit [2][NUM_CH];
  int     m_mode [2];
  int     m_dl [2];
  longint m_max [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit jump_word(input logic [31:0] w);
    return (w[31:26] == 6'd2) || (w[31:26] == 6'd3) || (w[31:26] == 6'd0 && w[5:0] == 6'd8);
  endfunction

  function automatic longint clamp(input longint v, input longint mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic bit hit_rule(input longint acc, input longint miss);
    longint a, d;
    a = acc * MISS_PEN;
    d = (miss >= a) ? 0 : a - miss;
    return (a != 0) && (100 * d > HIT_PCT * a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_mode[i] = M_IDLE; m_dl[i] = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_acc[i][k] = 0; m_miss[i][k] = 0; m_hit[i][k] = 0;
      end
    end
  endtask

  // Applies the current inputs as one rising edge of instance i.
  task automatic model_step(input int i);
    bit limit, halt;
    if (start) begin
      model_reset_one(i);
      m_mode[i] = M_RUN;
      return;
    end
    if (m_mode[i] != M_RUN && m_mode[i] != M_DRAIN) return;
    limit = (m_mode[i] == M_RUN) && (m_cyc[i] == TIMEOUT - 1);
    halt  = (m_mode[i] == M_RUN) && (cache_w[0] == HALT) && !ch_stall[0];
    m_cyc[i] = clamp(m_cyc[i] + 1, m_max[i]);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!ch_stall[k])
        m_acc[i][k] = clamp(m_acc[i][k] + (jump_word(cache_w[k]) ? 1 - FLUSH_SLOTS : 1), m_max[i]);
      else
        m_miss[i][k] = clamp(m_miss[i][k] + (jump_word(mem_w[k]) ? 1 - FLUSH_SLOTS : 1), m_max[i]);
    end
    if (m_mode[i] == M_RUN) begin
      if (limit) m_mode[i] = M_TOUT;
      else if (halt) begin m_mode[i] = M_DRAIN; m_dl[i] = DRAIN; end
    end else begin
      m_dl[i]--;
      if (m_dl[i] == 0) begin
        m_mode[i] = M_DONE;
        for (int k = 0; k < NUM_CH; k++) m_hit[i][k] = hit_rule(m_acc[i][k], m_miss[i][k]);
      end
    end
  endtask

  task automatic model_reset_one(input int i);
    m_cyc[i] = 0; m_mode[i] = M_IDLE; m_dl[i] = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_acc[i][k] = 0; m_miss[i][k] = 0; m_hit[i][k] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      ch_stall[k] = 1'b0; cache_w[k] = NOP; mem_w[k] = NOP;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0: w = J_W;
      1: w = JAL_W;
      2: w = JR_W;
      3: w = {6'd0, 20'($urandom), 6'b001000};
      4: w = $urandom;
      default: w = {6'd0, 20'($urandom), 6'h20};
    endcase
    return w;
  endfunction

  task automatic rand_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      ch_stall[k] = ($urandom_range(0, 2) == 0);
      cache_w[k]  = rand_word();
      mem_w[k]    = rand_word();
    end
    if ($urandom_range(0, 24) == 0) cache_w[0] = HALT;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] exp_q[$];
    for (int i = 0; i < 2; i++) begin
      exp_q.delete();
      exp_q.push_back(64'(m_cyc[i]));
      for (int k = 0; k < NUM_CH; k++) begin
        exp_q.push_back(64'(m_acc[i][k]));
        exp_q.push_back(64'(m_miss[i][k]));
        exp_q.push_back(64'(m_hit[i][k]));
      end
      exp_q.push_back(64'(m_mode[i] == M_RUN || m_mode[i] == M_DRAIN));
      exp_q.push_back(64'(m_mode[i] == M_DONE));
      exp_q.push_back(64'(m_mode[i] == M_TOUT));
      exp_q.push_back(64'(m_mode[i] != M_IDLE));

      check($sformatf("%s/i%0d/cycle", tag, i),
            (i == 0) ? 64'(cycle_cnt) : 64'(s_cycle_cnt), exp_q.pop_front());
      for (int k = 0; k < NUM_CH; k++) begin
        check($sformatf("%s/i%0d/acc%0d", tag, i, k),
              (i == 0) ? 64'(access_cnt[k*CNT_W +: CNT_W]) : 64'(s_access_cnt[k*SMALL_W +: SMALL_W]),
              exp_q.pop_front());
        check($sformatf("%s/i%0d/miss%0d", tag, i, k),
              (i == 0) ? 64'(miss_cyc[k*CNT_W +: CNT_W]) : 64'(s_miss_cyc[k*SMALL_W +: SMALL_W]),
              exp_q.pop_front());
        check($sformatf("%s/i%0d/hit%0d", tag, i, k),
              (i == 0) ? 64'(hit_ok[k]) : 64'(s_hit_ok[k]), exp_q.pop_front());
      end
      check($sformatf("%s/i%0d/running", tag, i), (i == 0) ? 64'(running) : 64'(s_running), exp_q.pop_front());
      check($sformatf("%s/i%0d/done", tag, i), (i == 0) ? 64'(done) : 64'(s_done), exp_q.pop_front());
      check($sformatf("%s/i%0d/timeout", tag, i), (i == 0) ? 64'(timeout) : 64'(s_timeout), exp_q.pop_front());
      check($sformatf("%s/i%0d/active", tag, i),
            (i == 0) ? 64'(dbg_state != 3'd0) : 64'(s_dbg_state != 3'd0), exp_q.pop_front());
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int     n_cyc;      // cycles before the halt word
    int     stall_of4;  // ch0 stalled on the first N cycles of every 4
    longint e_cyc;
    longint e_acc;
    longint e_miss;
    bit     e_hit;
  } vec_t;

  vec_t tbl [6];

  // ---------------- main sequence ----------------
  initial begin
    m_max[0] = (longint'(1) << CNT_W) - 1;
    m_max[1] = (longint'(1) << SMALL_W) - 1;

    tbl[0] = '{10, 0, 14, 14,  0, 1'b1};
    tbl[1] = '{24, 2, 28, 16, 12, 1'b1};
    tbl[2] = '{24, 3, 28, 10, 18, 1'b0};
    tbl[3] = '{ 8, 4, 12,  4,  8, 1'b0};
    tbl[4] = '{ 0, 0,  4,  4,  0, 1'b1};
    tbl[5] = '{ 8, 3, 12,  6,  6, 1'b0};  // exactly 50%: not strictly greater

    rst = 1'b0; start = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b1;

    // Table-driven runs; ch1 gets its own random stimulus.
    for (int r = 0; r < 6; r++) begin
      idle_inputs(); start = 1'b1; tick();
      for (int j = 0; j < tbl[r].n_cyc; j++) begin
        ch_stall[0] = ((j % 4) < tbl[r].stall_of4);
        ch_stall[1] = ($urandom_range(0, 1) == 0);
        cache_w[1] = rand_word(); mem_w[1] = rand_word();
        tick();
      end
      ch_stall[0] = 1'b0; cache_w[0] = HALT; tick();
      cache_w[0] = NOP;
      repeat (DRAIN) tick();
      check($sformatf("tbl%0d/cycle", r), 64'(cycle_cnt), 64'(tbl[r].e_cyc));
      check($sformatf("tbl%0d/acc0", r), 64'(access_cnt[CNT_W-1:0]), 64'(tbl[r].e_acc));
      check($sformatf("tbl%0d/miss0", r), 64'(miss_cyc[CNT_W-1:0]), 64'(tbl[r].e_miss));
      check($sformatf("tbl%0d/hit0", r), 64'(hit_ok[0]), 64'(tbl[r].e_hit));
      check($sformatf("tbl%0d/done", r), 64'(done), 64'(1));
      compare_all($sformatf("tbl%0d", r));
    end

    // Jump corrections and clamp at zero.
    idle_inputs(); start = 1'b1; tick();
    repeat (5) tick();
    check("jmp/acc_pre", 64'(access_cnt[CNT_W-1:0]), 64'd5);
    cache_w[0] = J_W; tick();
    check("jmp/acc_j", 64'(access_cnt[CNT_W-1:0]), 64'd4);
    cache_w[0] = NOP; ch_stall[0] = 1'b1; tick();
    check("jmp/miss_pre", 64'(miss_cyc[CNT_W-1:0]), 64'd1);
    mem_w[0] = JR_W; tick();
    check("jmp/miss_jr", 64'(miss_cyc[CNT_W-1:0]), 64'd0);
    idle_inputs(); start = 1'b1; tick();
    cache_w[0] = J_W; tick();
    check("jmp/clamp_j", 64'(access_cnt[CNT_W-1:0]), 64'd0);
    cache_w[0] = JAL_W; tick();
    check("jmp/clamp_jal", 64'(access_cnt[CNT_W-1:0]), 64'd0);
    cache_w[0] = NOP; tick();
    check("jmp/after", 64'(access_cnt[CNT_W-1:0]), 64'd1);
    compare_all("jmp");

    // Halt under stall is ignored; a second halt during drain is ignored.
    idle_inputs(); start = 1'b1; tick();
    ch_stall[0] = 1'b1; cache_w[0] = HALT;
    repeat (2) tick();
    check("stallhalt/running", 64'(running), 64'd1);
    ch_stall[0] = 1'b0; tick();
    repeat (2) tick();
    check("drainhalt/done_early", 64'(done), 64'd0);
    tick();
    check("drainhalt/done", 64'(done), 64'd1);
    check("drainhalt/cycle", 64'(cycle_cnt), 64'd6);
    compare_all("halt");

    // Timeout, with the halt word arriving on the limit cycle.
    idle_inputs(); start = 1'b1; tick();
    repeat (TIMEOUT - 1) tick();
    check("tout/before", 64'(timeout), 64'd0);
    check("tout/cycle_before", 64'(cycle_cnt), 64'(TIMEOUT - 1));
    cache_w[0] = HALT; tick();
    check("tout/flag", 64'(timeout), 64'd1);
    check("tout/done", 64'(done), 64'd0);
    check("tout/running", 64'(running), 64'd0);
    check("tout/cycle", 64'(cycle_cnt), 64'(TIMEOUT));
    check("tout/hit", 64'(hit_ok), 64'd0);
    cache_w[0] = NOP; repeat (5) tick();
    check("tout/frozen_cycle", 64'(cycle_cnt), 64'(TIMEOUT));
    check("tout/frozen_acc", 64'(access_cnt[CNT_W-1:0]), 64'(TIMEOUT));
    compare_all("tout");

    // Asynchronous reset in the middle of DRAIN, then a fresh run.
    idle_inputs(); start = 1'b1; tick();
    repeat (5) tick();
    cache_w[0] = HALT; tick();
    cache_w[0] = NOP; tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst/running", 64'(running), 64'd0);
    check("arst/cycle", 64'(cycle_cnt), 64'd0);
    compare_all("arst");
    #1 rst = 1'b1;
    start = 1'b1; tick();
    repeat (3) tick();
    check("arst/restart_cycle", 64'(cycle_cnt), 64'd3);
    compare_all("restart");

    // Saturation of the narrow instance.
    idle_inputs(); start = 1'b1; tick();
    repeat (20) tick();
    check("sat/small_acc0", 64'(s_access_cnt[SMALL_W-1:0]), 64'd15);
    check("sat/small_cycle", 64'(s_cycle_cnt), 64'd15);
    check("sat/big_acc0", 64'(access_cnt[CNT_W-1:0]), 64'd20);
    compare_all("sat");

    // Randomised runs against the model.
    for (int r = 0; r < 40; r++) begin
      idle_inputs(); start = 1'b1; tick();
      for (int j = 0; j < int'($urandom_range(10, 60)); j++) begin
        rand_inputs();
        if ($urandom_range(0, 99) == 0) start = 1'b1;
        tick();
        if ((j % 8) == 7) compare_all($sformatf("rand%0d", r));
      end
      idle_inputs();
      repeat (DRAIN + 1) tick();
      compare_all($sformatf("rand%0d_end", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
